memory_access_unit: RTL

- Memory-stage load/store unit. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts the M-stage load/store request into a word-aligned data-memory bus transaction with byte enables.
- Stalls the pipeline until the bus acknowledges the access or a timeout occurs.
- Returns sign- or zero-extended load data as ReadDataM, which the MEM/WB register captures.

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/lsu_load_align.sv | 26 ++
 rtl/memory_access_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the memory-stage load/store path.
package riscv_mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Load lane selection and sign/zero extension of the returned bus word.
module lsu_load_align
  import riscv_mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr, 3'b000};

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'b0, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'b0, shifted[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// M-stage load/store unit: bus request, byte enables, stall and timeout.
// state | meaning
// IDLE  | no transaction outstanding; a legal access issues combinationally
// BUSY  | request outstanding, waiting for dmem_ack or timeout
module memory_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AluResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignedM,
  output logic        BusErrorM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic            access, is_store, legal, busy, timeout;
  logic [3:0]      be_raw;
  logic [31:0]     load_data;

  assign access   = MemReadM | MemWriteM;
  assign is_store = MemWriteM;
  assign busy     = (state == BUSY);

  always_comb begin
    legal = 1'b0;
    case (Funct3M)
      F3_B:    legal = 1'b1;
      F3_BU:   legal = !is_store;
      F3_H:    legal = !AluResultM[0];
      F3_HU:   legal = !is_store & !AluResultM[0];
      F3_W:    legal = (AluResultM[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // cnt counts wait cycles including the issue cycle, so the error lands in
  // cycle TIMEOUT_CYCLES of the transaction.
  assign timeout     = busy & !dmem_ack & TO_EN & (cnt >= CNT_LAST);
  assign dmem_req    = !reset & (busy | (access & legal));
  assign MisalignedM = !reset & !busy & access & !legal;
  assign BusErrorM   = !reset & timeout;
  assign StallM      = dmem_req & !dmem_ack & !timeout;

  assign dmem_we   = is_store;
  assign dmem_addr = {AluResultM[31:2], 2'b00};
  assign dmem_be   = dmem_req ? be_raw : 4'b0000;

  always_comb begin
    be_raw     = 4'b1111;
    dmem_wdata = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        be_raw     = 4'b0001 << AluResultM[1:0];
        dmem_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_raw     = AluResultM[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_raw     = 4'b1111;
        dmem_wdata = WriteDataM;
      end
    endcase
  end

  lsu_load_align u_align (
    .rdata  (dmem_rdata),
    .addr   (AluResultM[1:0]),
    .funct3 (Funct3M),
    .result (load_data)
  );

  assign ReadDataM = (dmem_req & dmem_ack & !is_store) ? load_data : 32'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_req & !dmem_ack) begin
            state <= BUSY;
            cnt   <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (dmem_ack | timeout) state <= IDLE;
          else                    cnt   <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
